// File: rtl/match_tracker.sv
// rtl/match_tracker.sv - match scorekeeper: counts rounds/wins/losses, flags finish and winner.
// Optional early finish on a decided outcome is enabled by defining EARLY_FINISH_EN.
module match_tracker #(
    parameter int ROUNDS = 9,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             result_valid,
    input  logic [1:0]       result,
    output logic             result_ready,
    output logic [CNT_W-1:0] round,
    output logic [CNT_W-1:0] win,
    output logic [CNT_W-1:0] lose,
    output logic             fin,
    output logic             fin_pulse,
    output logic [1:0]       printwinner
);

    typedef enum logic {PLAY, DONE} state_t;

    localparam logic [CNT_W:0]   ROUNDS_X = (CNT_W+1)'(ROUNDS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] round_nx, win_nx, lose_nx;
    logic             fin_nx, pulse_nx, ready_nx;
    logic [1:0]       pw_nx;
    logic [CNT_W:0]   w_ext, l_ext, remaining;
    logic             accept, counted, decided;

    always_comb begin
        state_nx  = state;
        round_nx  = round;
        win_nx    = win;
        lose_nx   = lose;
        fin_nx    = fin;
        pw_nx     = printwinner;
        pulse_nx  = 1'b0;

        accept  = (state == PLAY) && result_valid;
        counted = accept && (result != 2'b00);

        if (counted) begin
            round_nx = round + ONE;
            if (result == 2'b01) win_nx  = win + ONE;
            if (result == 2'b10) lose_nx = lose + ONE;
        end

        // Lead checks are done one bit wider so l + remaining cannot wrap.
        w_ext     = {1'b0, win_nx};
        l_ext     = {1'b0, lose_nx};
        remaining = ROUNDS_X - {1'b0, round_nx};
        decided   = ({1'b0, round_nx} == ROUNDS_X);
`ifdef EARLY_FINISH_EN
        decided = decided || (w_ext > l_ext + remaining) || (l_ext > w_ext + remaining);
`else
        decided = decided && (remaining == '0);
`endif

        if (counted && decided) begin
            state_nx = DONE;
            fin_nx   = 1'b1;
            pulse_nx = 1'b1;
            if (w_ext > l_ext)      pw_nx = 2'b10;
            else if (l_ext > w_ext) pw_nx = 2'b11;
            else                    pw_nx = 2'b01;
        end

        // A same-cycle result is dropped when a new match starts.
        if (clear) begin
            state_nx = PLAY;
            round_nx = '0;
            win_nx   = '0;
            lose_nx  = '0;
            fin_nx   = 1'b0;
            pulse_nx = 1'b0;
            pw_nx    = 2'b00;
        end

        ready_nx = (state_nx == PLAY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= PLAY;
            round        <= '0;
            win          <= '0;
            lose         <= '0;
            fin          <= 1'b0;
            fin_pulse    <= 1'b0;
            printwinner  <= 2'b00;
            result_ready <= 1'b1;
        end else begin
            state        <= state_nx;
            round        <= round_nx;
            win          <= win_nx;
            lose         <= lose_nx;
            fin          <= fin_nx;
            fin_pulse    <= pulse_nx;
            printwinner  <= pw_nx;
            result_ready <= ready_nx;
        end
    end

endmodule

// File: tb/tb_match_tracker.sv
// tb/tb_match_tracker.sv - directed self-checking bench for match_tracker (ROUNDS=9, CNT_W=4).
module tb_match_tracker;

    logic       clk = 1'b0;
    logic       rst_n, clear, result_valid;
    logic [1:0] result;
    logic       result_ready, fin, fin_pulse;
    logic [3:0] round, win, lose;
    logic [1:0] printwinner;

    int checks = 0;
    int errors = 0;
    int pulses;
    int pulse_at;

    match_tracker #(.ROUNDS(9), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .result_valid(result_valid), .result(result),
        .result_ready(result_ready), .round(round), .win(win), .lose(lose),
        .fin(fin), .fin_pulse(fin_pulse), .printwinner(printwinner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r);
        result_valid = 1'b1;
        result       = r;
        step();
        result_valid = 1'b0;
    endtask

    task automatic new_match();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    logic [1:0] seq_a [9] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
    logic [1:0] seq_d [11] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11};

    initial begin
        rst_n = 1'b0; clear = 1'b0; result_valid = 1'b1; result = 2'b01;
        step();
        step();
        check("rst_round", round, 0);
        check("rst_win", win, 0);
        check("rst_lose", lose, 0);
        check("rst_fin", fin, 0);
        check("rst_pulse", fin_pulse, 0);
        check("rst_pw", printwinner, 2'b00);
        check("rst_ready", result_ready, 1);

        // p1 wins 6-2 after losing the first two rounds
        rst_n = 1'b1; result_valid = 1'b0;
        pulses = 0; pulse_at = 0;
        for (int i = 0; i < 9; i++) begin
            drive(seq_a[i]);
            if (fin_pulse) begin
                pulses++;
                pulse_at = i + 1;
            end
        end
        check("a_pulses", pulses, 1);
`ifdef EARLY_FINISH_EN
        check("a_pulse_at", pulse_at, 7);
        check("a_round", round, 7);
        check("a_win", win, 5);
`else
        check("a_pulse_at", pulse_at, 9);
        check("a_round", round, 9);
        check("a_win", win, 6);
`endif
        check("a_lose", lose, 2);
        check("a_fin", fin, 1);
        check("a_pw", printwinner, 2'b10);
        check("a_ready", result_ready, 0);
        step();
        check("a_pulse_low", fin_pulse, 0);
        check("a_fin_hold", fin, 1);

        // results ignored in DONE
        for (int i = 0; i < 3; i++) drive(2'b01);
`ifdef EARLY_FINISH_EN
        check("done_round", round, 7);
        check("done_win", win, 5);
`else
        check("done_round", round, 9);
        check("done_win", win, 6);
`endif
        check("done_ready", result_ready, 0);
        check("done_pulse", fin_pulse, 0);

        // clear wins over a same-cycle result
        clear = 1'b1; result_valid = 1'b1; result = 2'b01;
        step();
        clear = 1'b0; result_valid = 1'b0;
        check("clr_round", round, 0);
        check("clr_win", win, 0);
        check("clr_fin", fin, 0);
        check("clr_pw", printwinner, 2'b00);
        check("clr_ready", result_ready, 1);

        // 4-4-1 draw with void rounds interleaved
        for (int i = 0; i < 11; i++) begin
            drive(seq_d[i]);
            if (i == 1) check("d_void_round", round, 1);
            if (i == 9) check("d_fin_early", fin, 0);
        end
        check("d_round", round, 9);
        check("d_win", win, 4);
        check("d_lose", lose, 4);
        check("d_fin", fin, 1);
        check("d_pulse", fin_pulse, 1);
        check("d_pw", printwinner, 2'b01);

        // five straight p2 wins
        new_match();
        for (int i = 0; i < 5; i++) drive(2'b10);
        check("e_round", round, 5);
        check("e_lose", lose, 5);
`ifdef EARLY_FINISH_EN
        check("e_fin", fin, 1);
        check("e_pw", printwinner, 2'b11);
        check("e_ready", result_ready, 0);
`else
        check("e_fin", fin, 0);
        check("e_pw", printwinner, 2'b00);
        check("e_ready", result_ready, 1);
`endif

        // reset mid-match
        new_match();
        for (int i = 0; i < 4; i++) drive(2'b01);
        check("m_round", round, 4);
        rst_n = 1'b0; result_valid = 1'b1; result = 2'b01;
        step();
        rst_n = 1'b1; result_valid = 1'b0;
        check("m_rst_round", round, 0);
        check("m_rst_win", win, 0);
        check("m_rst_fin", fin, 0);
        check("m_rst_ready", result_ready, 1);
        drive(2'b01);
        check("m_after_round", round, 1);
        check("m_after_win", win, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
